// File: rtl/image_sensor_model.sv
// -----------------------------------------------------------------------------
// image_sensor_model
//
// Synthesizable image sensor emulator. It is the responder side of the
// frame-capture handshake used by the sensor interface block, and stands in
// for a real sensor on FPGA builds and in system-level benches.
//
// When a capture request is accepted, the block latches the pattern select and
// the constant value. It optionally waits EXPOSE_CYCLES idle cycles, then
// streams NUM_PIXELS pixels back to back, one per cycle. Finally it pulses
// out_done for one cycle and increments the completed-frame counter.
//
// Optional build macro:
//   IMGSENSOR_NOISE_EN
//     Adds a 9-bit Fibonacci LFSR (x^9 + x^5 + 1). The LFSR perturbs the low
//     two bits of every streamed pixel. When the macro is not defined, no LFSR
//     logic exists and pixels are exactly the pattern value.
//
// Parameters:
//   DATA_W         pixel width in bits
//   NUM_PIXELS     pixels per frame (power of two, >= 2)
//   COL_BITS       log2 of the row width; drives the checkerboard
//   EXPOSE_CYCLES  idle cycles between acceptance and pixel 0 (0..255)
//
// Ports:
//   in_clk            clock, rising edge
//   in_rst            asynchronous, active-high reset
//   in_frame_capture  frame request, level-sampled in IDLE only
//   in_pattern_sel    0 ramp, 1 constant, 2 checkerboard, 3 frame-offset ramp
//   in_const          value used by the constant pattern
//   out_data_read     current pixel; zero whenever out_valid is low
//   out_valid         out_data_read holds a pixel this cycle
//   out_done          one-cycle frame-complete pulse
//   out_busy          high from capture acceptance until out_done
//   out_frame_cnt     completed-frame count, wraps 255 -> 0
// -----------------------------------------------------------------------------
module image_sensor_model #(
  parameter int DATA_W        = 9,
  parameter int NUM_PIXELS    = 64,
  parameter int COL_BITS      = 3,
  parameter int EXPOSE_CYCLES = 0
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_frame_capture,
  input  logic [1:0]        in_pattern_sel,
  input  logic [DATA_W-1:0] in_const,
  output logic [DATA_W-1:0] out_data_read,
  output logic              out_valid,
  output logic              out_done,
  output logic              out_busy,
  output logic [7:0]        out_frame_cnt
);

  localparam int IDX_W = $clog2(NUM_PIXELS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);
  // Exposure counter compares against the last count value; with no exposure
  // phase the comparison is never reached, so the value 0 is unused.
  localparam logic [7:0] EXP_LAST = (EXPOSE_CYCLES > 0) ? 8'(EXPOSE_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPOSE = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] PAT_RAMP   = 2'd0;
  localparam logic [1:0] PAT_CONST  = 2'd1;
  localparam logic [1:0] PAT_CHECK  = 2'd2;
  localparam logic [1:0] PAT_OFFSET = 2'd3;

  // Control state
  state_e            state_q,     state_d;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [7:0]        exp_cnt_q,   exp_cnt_d;
  logic [1:0]        sel_q,       sel_d;
  logic [DATA_W-1:0] const_q,     const_d;
  logic [7:0]        offset_q,    offset_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  // Registered outputs
  logic [DATA_W-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              done_q,  done_d;
  logic              busy_q,  busy_d;

  // Pattern value for the pixel about to be registered
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] pixel;

`ifdef IMGSENSOR_NOISE_EN
  logic [8:0] lfsr_q, lfsr_d;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every flop, including the outputs, is cleared by the asynchronous
  // reset. A reset mid-frame therefore drops the outputs to zero at once,
  // without waiting for a clock edge.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      // NOTE: sequential state uses non-blocking assignments only. All flops
      // then update together from the values sampled before the edge.
      state_q     <= S_IDLE;
      idx_q       <= '0;
      exp_cnt_q   <= '0;
      sel_q       <= '0;
      const_q     <= '0;
      offset_q    <= '0;
      frame_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef IMGSENSOR_NOISE_EN
      lfsr_q      <= 9'h1FF;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exp_cnt_q   <= exp_cnt_d;
      sel_q       <= sel_d;
      const_q     <= const_d;
      offset_q    <= offset_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef IMGSENSOR_NOISE_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first. No path can then leave a
    // variable unassigned, so no latch is inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    exp_cnt_d   = exp_cnt_q;
    sel_d       = sel_q;
    const_d     = const_q;
    offset_d    = offset_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_frame_capture) begin
          // Configuration is frozen here; later changes to the pattern or
          // constant inputs cannot disturb the frame in flight.
          sel_d     = in_pattern_sel;
          const_d   = in_const;
          offset_d  = frame_cnt_q;
          idx_d     = '0;
          exp_cnt_d = '0;
          state_d   = (EXPOSE_CYCLES > 0) ? S_EXPOSE : S_STREAM;
        end
      end

      S_EXPOSE: begin
        if (exp_cnt_q == EXP_LAST) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end else begin
          exp_cnt_d = exp_cnt_q + 8'd1;
        end
      end

      S_STREAM: begin
        if (idx_q == IDX_LAST) begin
          state_d     = S_DONE;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        // A request that is still held high is seen only once back in IDLE.
        // This guarantees one idle cycle between frames.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // The outputs are registered. They are therefore computed from the *next*
  // state and index, so that pixel 0 is visible in the cycle right after
  // the edge that moves into STREAM.
  always_comb begin
    pattern = '0;
    unique case (sel_d)
      PAT_RAMP:   pattern = DATA_W'(idx_d);
      PAT_CONST:  pattern = const_d;
      PAT_CHECK:  pattern = (idx_d[COL_BITS] ^ idx_d[0]) ? '1 : '0;
      PAT_OFFSET: pattern = DATA_W'(idx_d) + DATA_W'(offset_d);
      default:    pattern = '0;
    endcase
  end

  always_comb begin
    valid_d = (state_d == S_STREAM);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d == S_EXPOSE) || (state_d == S_STREAM);

`ifdef IMGSENSOR_NOISE_EN
    pixel  = pattern ^ DATA_W'(lfsr_q[1:0]);
    // The LFSR steps once per presented pixel and keeps running across frames.
    lfsr_d = valid_d ? {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]} : lfsr_q;
`else
    pixel  = pattern;
`endif

    data_d = valid_d ? pixel : '0;
  end

  assign out_data_read = data_q;
  assign out_valid     = valid_q;
  assign out_done      = done_q;
  assign out_busy      = busy_q;
  assign out_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_image_sensor_model.sv
// -----------------------------------------------------------------------------
// tb_image_sensor_model
//
// Directed bench for image_sensor_model, default build (no noise).
//
// It uses two instances:
//   dut0  EXPOSE_CYCLES = 0
//         ramp, checkerboard, back-to-back, frame-offset wrap and reset abort
//   dut3  EXPOSE_CYCLES = 3
//         constant pattern with an exposure phase
//
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_image_sensor_model;

  localparam int DATA_W     = 9;
  localparam int NUM_PIXELS = 64;

  logic              in_clk;
  logic              in_rst;
  logic              cap0;
  logic              cap3;
  logic [1:0]        in_pattern_sel;
  logic [DATA_W-1:0] in_const;

  logic [DATA_W-1:0] data0,  data3;
  logic              valid0, valid3;
  logic              done0,  done3;
  logic              busy0,  busy3;
  logic [7:0]        cnt0,   cnt3;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] pix_log [NUM_PIXELS];

  image_sensor_model #(
    .DATA_W(DATA_W), .NUM_PIXELS(NUM_PIXELS), .COL_BITS(3), .EXPOSE_CYCLES(0)
  ) dut0 (
    .in_clk           (in_clk),
    .in_rst           (in_rst),
    .in_frame_capture (cap0),
    .in_pattern_sel   (in_pattern_sel),
    .in_const         (in_const),
    .out_data_read    (data0),
    .out_valid        (valid0),
    .out_done         (done0),
    .out_busy         (busy0),
    .out_frame_cnt    (cnt0)
  );

  image_sensor_model #(
    .DATA_W(DATA_W), .NUM_PIXELS(NUM_PIXELS), .COL_BITS(3), .EXPOSE_CYCLES(3)
  ) dut3 (
    .in_clk           (in_clk),
    .in_rst           (in_rst),
    .in_frame_capture (cap3),
    .in_pattern_sel   (in_pattern_sel),
    .in_const         (in_const),
    .out_data_read    (data3),
    .out_valid        (valid3),
    .out_done         (done3),
    .out_busy         (busy3),
    .out_frame_cnt    (cnt3)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Reference pixel value, written directly from the pattern definitions.
  function automatic logic [DATA_W-1:0] exp_pix(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] cst,
                                                input int k, input int off);
    int row, col;
    row = k / 8;
    col = k % 8;
    case (sel)
      2'd0:    return DATA_W'(k);
      2'd1:    return cst;
      2'd2:    return ((row % 2) != (col % 2)) ? 9'h1FF : 9'h000;
      default: return DATA_W'((k + off) % 512);
    endcase
  endfunction

  // Entered with pixel 0 of dut0 visible. Exits in the DONE cycle.
  task automatic stream_frame0(input string tag, input logic [1:0] sel,
                               input logic [DATA_W-1:0] cst, input int off);
    for (int k = 0; k < NUM_PIXELS; k++) begin
      pix_log[k] = data0;
      check($sformatf("%s_pix%0d", tag, k), {valid0, busy0, data0},
            {1'b1, 1'b1, exp_pix(sel, cst, k, off)});
      tick();
    end
    check({tag, "_done"}, {done0, valid0, busy0, data0}, {1'b1, 1'b0, 1'b0, 9'h000});
  endtask

  initial begin
    int n;

    in_rst         = 1'b1;
    cap0           = 1'b0;
    cap3           = 1'b0;
    in_pattern_sel = 2'd0;
    in_const       = '0;
    tick();
    tick();

    // Reset state
    check("rst_dut0", {data0, valid0, done0, busy0, cnt0}, '0);
    check("rst_dut3", {data3, valid3, done3, busy3, cnt3}, '0);
    in_rst = 1'b0;
    tick();
    check("idle_after_rst", {data0, valid0, done0, busy0, cnt0}, '0);

    // Ramp, single-cycle request, pixel 0 on the cycle after acceptance
    in_pattern_sel = 2'd0;
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    stream_frame0("ramp", 2'd0, 9'h000, 0);
    check("ramp_cnt", cnt0, 8'd1);
    tick();
    check("ramp_done_one_cycle", {done0, valid0, busy0}, 3'b000);
    tick();
    check("ramp_stays_idle", {done0, valid0, busy0}, 3'b000);

    // Constant with 3 exposure cycles; inputs disturbed mid-frame
    in_pattern_sel = 2'd1;
    in_const       = 9'h155;
    cap3 = 1'b1;
    tick();
    cap3 = 1'b0;
    for (int e = 0; e < 3; e++) begin
      check($sformatf("expose%0d", e), {busy3, valid3, data3}, {1'b1, 1'b0, 9'h000});
      tick();
    end
    for (int k = 0; k < NUM_PIXELS; k++) begin
      if (k == 10) begin
        in_const       = 9'h0AA;
        in_pattern_sel = 2'd2;
      end
      check($sformatf("const_pix%0d", k), {valid3, data3}, {1'b1, 9'h155});
      tick();
    end
    check("const_done", {done3, valid3, busy3, cnt3}, {1'b1, 1'b0, 1'b0, 8'd1});

    // Checkerboard on dut0
    in_pattern_sel = 2'd2;
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    stream_frame0("chk", 2'd2, 9'h000, 0);
    check("chk_p0",  pix_log[0],  9'h000);
    check("chk_p1",  pix_log[1],  9'h1FF);
    check("chk_p8",  pix_log[8],  9'h1FF);
    check("chk_p9",  pix_log[9],  9'h000);
    check("chk_p63", pix_log[63], 9'h000);
    check("chk_cnt", cnt0, 8'd2);
    tick();

    // Request held high: run ramp frames back to back until 255 frames
    // have completed.
    in_pattern_sel = 2'd0;
    cap0 = 1'b1;
    n = 0;
    while (!(done0 && cnt0 == 8'd255) && n < 20000) begin
      tick();
      n++;
    end
    check("ff_reach255", {done0, cnt0}, {1'b1, 8'd255});

    // Back-to-back gap: one DONE cycle (now), then one IDLE cycle
    in_pattern_sel = 2'd3;
    tick();
    check("b2b_idle", {done0, valid0, busy0}, 3'b000);
    tick();
    stream_frame0("offs255", 2'd3, 9'h000, 255);
    check("offs255_wrap", cnt0, 8'd0);
    tick();
    check("b2b_idle2", {done0, valid0, busy0}, 3'b000);
    tick();
    cap0 = 1'b0;
    stream_frame0("offs0", 2'd3, 9'h000, 0);
    check("offs0_cnt", cnt0, 8'd1);
    tick();
    tick();
    check("released_idle", {done0, valid0, busy0}, 3'b000);

    // Reset asserted at pixel 20 aborts the frame
    in_pattern_sel = 2'd0;
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("pre_abort_pix20", {valid0, data0}, {1'b1, 9'd20});
    #2;
    in_rst = 1'b1;
    #1;
    check("abort_async", {data0, valid0, done0, busy0, cnt0}, '0);
    tick();
    check("abort_no_done_a", {done0, valid0}, 2'b00);
    tick();
    check("abort_no_done_b", {done0, valid0}, 2'b00);
    in_rst = 1'b0;
    tick();
    check("abort_idle", {done0, valid0, busy0, cnt0}, '0);
    cap0 = 1'b1;
    tick();
    cap0 = 1'b0;
    check("restart_cnt", cnt0, 8'd0);
    stream_frame0("restart", 2'd0, 9'h000, 0);
    check("restart_cnt_after", cnt0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/image_sensor_model.md
Name: image_sensor_model

Overview:
- Synthesizable image sensor emulator; the responder side of the frame-capture handshake used by the sensor interface block.
- On a frame-capture request it streams NUM_PIXELS pixels of DATA_W bits, one per cycle, then pulses done.
- Pixels come from a selectable test-pattern generator.
- Used in place of a real sensor on FPGA builds and in system-level benches.

Parameters:
- DATA_W, 9, pixel width in bits.
- NUM_PIXELS, 64, pixels per frame; power of two, at least 2.
- COL_BITS, 3, log2 of row width (8 pixels per row); used by the checkerboard pattern.
- EXPOSE_CYCLES, 0, idle cycles between capture acceptance and pixel 0; range 0..255.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_frame_capture  input  1  frame request; level-sampled.
- in_pattern_sel  input  2  pattern: 0 ramp, 1 constant, 2 checkerboard, 3 frame-offset ramp.
- in_const  input  DATA_W  value for constant pattern.
- out_data_read  output  DATA_W  current pixel.
- out_valid  output  1  out_data_read holds a pixel this cycle.
- out_done  output  1  one-cycle frame-complete pulse.
- out_busy  output  1  high from capture acceptance until out_done.
- out_frame_cnt  output  8  completed-frame count; wraps 255 to 0.

Behaviour:
- Reset is asynchronous: state IDLE; out_data_read=0, out_valid=0, out_done=0, out_busy=0, out_frame_cnt=0; pixel index and exposure counter cleared.
- All outputs are registered.
- States:
  - IDLE: waits for a request.
  - EXPOSE: counts EXPOSE_CYCLES cycles.
  - STREAM: presents pixels.
  - DONE: one cycle.
- IDLE: at an edge with in_frame_capture=1, latch in_pattern_sel and in_const.
  - out_busy goes to 1.
  - Next state is EXPOSE if EXPOSE_CYCLES>0, otherwise STREAM.
- Latency: with EXPOSE_CYCLES=0, pixel 0 is on out_data_read with out_valid=1 in the cycle immediately after the accepting edge. In general, pixel 0 appears EXPOSE_CYCLES cycles later.
- STREAM:
  - Pixel k is presented for exactly one cycle; k runs 0..NUM_PIXELS-1, with no gaps and no backpressure.
  - After pixel NUM_PIXELS-1, go to DONE.
- DONE, single cycle:
  - out_valid=0, out_data_read=0, out_done=1, out_busy=0.
  - out_frame_cnt increments.
  - Return to IDLE.
- A capture request can be accepted at the earliest one cycle after DONE.
- out_data_read is 0 whenever out_valid=0.
- Patterns, where idx is the pixel index, row=idx>>COL_BITS and col=idx mod 2^COL_BITS:
  - ramp: idx zero-extended to DATA_W.
  - constant: latched in_const.
  - checkerboard: all-ones when row[0]^col[0], else 0.
  - frame-offset ramp: (idx + out_frame_cnt) mod 2^DATA_W, using out_frame_cnt as latched at acceptance.
- in_frame_capture is ignored outside IDLE; a level still held high in DONE is not accepted until IDLE.
- Pattern and constant inputs are ignored after acceptance.
- Reset asserted mid-frame aborts immediately: no out_done, frame count cleared.

Optional Feature:
- Macro: IMGSENSOR_NOISE_EN.
- When defined:
  - A 9-bit Fibonacci LFSR (x^9+x^5+1) is added, seed 9'h1FF on reset.
  - The LFSR advances once per streamed pixel and persists across frames.
  - Each streamed pixel = pattern XOR {0, lfsr[1:0]}, so only the low 2 bits are perturbed.
- When undefined: no LFSR logic; pixels are exactly the pattern value.

Test Plan:
- Ramp, EXPOSE_CYCLES=0: pulse in_frame_capture for 1 cycle.
  - Required: 64 consecutive valid cycles with values 0..63, starting the cycle after acceptance.
  - Then out_done high for 1 cycle, out_frame_cnt=1, out_busy low.
- Constant, in_const=9'h155, EXPOSE_CYCLES=3:
  - Required: 3 cycles of busy=1, valid=0; then 64 pixels of 0x155, then done.
  - Changing in_const mid-frame has no effect.
- Checkerboard:
  - Required: pixel 0=0, pixel 1=0x1FF, pixel 8=0x1FF, pixel 9=0, pixel 63=0.
- Frame-offset ramp after 255 completed frames:
  - Required: the next frame streams 255, 256, ... ; out_frame_cnt then wraps to 0.
  - The following frame starts at 0.
- in_frame_capture held high continuously:
  - Required: back-to-back frames separated by exactly one DONE and one IDLE cycle.
  - No request is accepted mid-stream.
- Assert in_rst at pixel 20:
  - Required: all outputs are 0 asynchronously and there is no out_done.
  - A new capture after reset restarts at pixel 0 with out_frame_cnt=0.
